// File: rtl/reg_xfer_sequencer_pkg.sv
// Shared types for the split-register transfer sequencer: transfer kinds,
// per-half register operations and the sequencer FSM state encoding.
package xfer_pkg;

    // Transfer kinds offered by the instruction decoder
    typedef enum logic [2:0] {
        MOVE     = 3'd0,
        MOVE_LO  = 3'd1,
        MOVE_HI  = 3'd2,
        LO_TO_HI = 3'd3,
        HI_TO_LO = 3'd4,
        LOAD_LO  = 3'd5,
        LOAD_HI  = 3'd6,
        EXCHANGE = 3'd7
    } xfer_kind_t;

    // Per-half register operation. WRITE drives the shared lane (and the
    // crossover lane when the other half is not also writing); SWRITENC
    // drives only its own lane; READ samples its own lane.
    typedef enum logic [1:0] {
        REG_OP_NONE     = 2'd0,
        REG_OP_READ     = 2'd1,
        REG_OP_WRITE    = 2'd2,
        REG_OP_SWRITENC = 2'd3
    } reg_op_t;

    // Each state names the step currently presented on the outputs
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_XFER = 2'd3
    } seq_state_t;

    // Step numbers inside an EXCHANGE
    localparam logic [1:0] STEP_1 = 2'd0;
    localparam logic [1:0] STEP_2 = 2'd1;
    localparam logic [1:0] STEP_3 = 2'd2;

    function automatic logic is_load(input xfer_kind_t k);
        return (k == LOAD_LO) || (k == LOAD_HI);
    endfunction

endpackage

// File: rtl/reg_xfer_sequencer_decode.sv
// Purely combinational step decoder: maps one (kind, src, dst, nib, step)
// to the per-register strobe vectors. Also flags requests that must be
// turned into an all-NONE error step.
module xfer_step_decode
    import xfer_pkg::*;
#(
    parameter int HALF_WIDTH = 4,
    parameter int NUM_REGS   = 4,
    parameter int TMP_REG    = NUM_REGS - 1,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                       active,
    input  xfer_kind_t                 kind,
    input  logic [IDX_W-1:0]           src,
    input  logic [IDX_W-1:0]           dst,
    input  logic [HALF_WIDTH-1:0]      nib,
    input  logic [1:0]                 step,
    output reg_op_t [NUM_REGS-1:0]     op_low,
    output reg_op_t [NUM_REGS-1:0]     op_high,
    output logic [NUM_REGS-1:0]        bus_b_low,
    output logic [NUM_REGS-1:0]        bus_b_high,
    output logic [HALF_WIDTH-1:0]      bus_b_out,
    output logic                       done,
    output logic                       err,
    output logic                       reject
);

    localparam logic [IDX_W-1:0] TMP_IDX = IDX_W'(TMP_REG);

    logic [IDX_W-1:0] mv_a;
    logic [IDX_W-1:0] mv_b;

    function automatic logic idx_bad(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} >= (IDX_W+1)'(NUM_REGS));
    endfunction

    // Validate the request fields independently of whether a step is active
    always_comb begin
        reject = idx_bad(src) || idx_bad(dst)
              || (!is_load(kind) && (src == dst))
              || ((kind == EXCHANGE) && ((src == TMP_IDX) || (dst == TMP_IDX)));
    end

    // Pick the source/destination of the full MOVE that an EXCHANGE step performs
    always_comb begin
        mv_a = src;
        mv_b = dst;
        if (kind == EXCHANGE) begin
            case (step)
                STEP_1:  begin mv_a = src;     mv_b = TMP_IDX; end
                STEP_2:  begin mv_a = dst;     mv_b = src;     end
                default: begin mv_a = TMP_IDX; mv_b = dst;     end
            endcase
        end
    end

    // Build the strobe vectors for the selected step
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            op_low[i]  = REG_OP_NONE;
            op_high[i] = REG_OP_NONE;
        end
        bus_b_low  = '0;
        bus_b_high = '0;
        bus_b_out  = '0;
        done       = 1'b0;
        err        = 1'b0;
        if (active) begin
            if (reject) begin
                done = 1'b1;
                err  = 1'b1;
            end else begin
                done = 1'b1;
                case (kind)
                    MOVE, EXCHANGE: begin
                        op_low[mv_a]  = REG_OP_WRITE;
                        op_high[mv_a] = REG_OP_WRITE;
                        op_low[mv_b]  = REG_OP_READ;
                        op_high[mv_b] = REG_OP_READ;
                        done = (kind == MOVE) || (step == STEP_3);
                    end
                    MOVE_LO: begin
                        op_low[src] = REG_OP_SWRITENC;
                        op_low[dst] = REG_OP_READ;
                    end
                    MOVE_HI: begin
                        op_high[src] = REG_OP_SWRITENC;
                        op_high[dst] = REG_OP_READ;
                    end
                    LO_TO_HI: begin
                        op_low[src]  = REG_OP_WRITE;
                        op_high[dst] = REG_OP_READ;
                    end
                    HI_TO_LO: begin
                        op_high[src] = REG_OP_WRITE;
                        op_low[dst]  = REG_OP_READ;
                    end
                    LOAD_LO: begin
                        bus_b_out      = nib;
                        bus_b_low[dst] = 1'b1;
                    end
                    default: begin
                        bus_b_out       = nib;
                        bus_b_high[dst] = 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/reg_xfer_sequencer.sv
// Transfer sequencer top: accepts one request at a time, drives registered
// per-register strobes for one step (or three for EXCHANGE) and pulses done.
// Handshake: a request is accepted on a posedge where req_valid && req_ready;
// its first step is on the outputs from that edge to the next one. req_valid
// while req_ready is low is ignored, never queued.
module reg_xfer_sequencer
    import xfer_pkg::*;
#(
    parameter int HALF_WIDTH = 4,
    parameter int NUM_REGS   = 4,
    parameter int TMP_REG    = NUM_REGS - 1,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  xfer_kind_t                 req_kind,
    input  logic [IDX_W-1:0]           req_src,
    input  logic [IDX_W-1:0]           req_dst,
    input  logic [HALF_WIDTH-1:0]      req_nib,
    output reg_op_t [NUM_REGS-1:0]     op_low,
    output reg_op_t [NUM_REGS-1:0]     op_high,
    output logic [NUM_REGS-1:0]        bus_b_low,
    output logic [NUM_REGS-1:0]        bus_b_high,
    output logic [HALF_WIDTH-1:0]      bus_b_out,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 dbg_state
);

    seq_state_t              state_q, state_d;
    xfer_kind_t              kind_q, kind_d;
    logic [IDX_W-1:0]        src_q, src_d;
    logic [IDX_W-1:0]        dst_q, dst_d;
    logic [HALF_WIDTH-1:0]   nib_q, nib_d;

    reg_op_t [NUM_REGS-1:0]  op_low_q, op_low_d;
    reg_op_t [NUM_REGS-1:0]  op_high_q, op_high_d;
    logic [NUM_REGS-1:0]     bus_b_low_q, bus_b_low_d;
    logic [NUM_REGS-1:0]     bus_b_high_q, bus_b_high_d;
    logic [HALF_WIDTH-1:0]   bus_b_out_q, bus_b_out_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic                    dec_active;
    xfer_kind_t              dec_kind;
    logic [IDX_W-1:0]        dec_src;
    logic [IDX_W-1:0]        dec_dst;
    logic [HALF_WIDTH-1:0]   dec_nib;
    logic [1:0]              dec_step;
    reg_op_t [NUM_REGS-1:0]  dec_op_low;
    reg_op_t [NUM_REGS-1:0]  dec_op_high;
    logic [NUM_REGS-1:0]     dec_bus_b_low;
    logic [NUM_REGS-1:0]     dec_bus_b_high;
    logic [HALF_WIDTH-1:0]   dec_bus_b_out;
    logic                    dec_done;
    logic                    dec_err;
    logic                    dec_reject;

    // State, latched request and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            kind_q       <= MOVE;
            src_q        <= '0;
            dst_q        <= '0;
            nib_q        <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                op_low_q[i]  <= REG_OP_NONE;
                op_high_q[i] <= REG_OP_NONE;
            end
            bus_b_low_q  <= '0;
            bus_b_high_q <= '0;
            bus_b_out_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            nib_q        <= nib_d;
            op_low_q     <= op_low_d;
            op_high_q    <= op_high_d;
            bus_b_low_q  <= bus_b_low_d;
            bus_b_high_q <= bus_b_high_d;
            bus_b_out_q  <= bus_b_out_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next state, request latch and next strobe values
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EX1:  state_d = ST_EX2;
            ST_EX2:  state_d = ST_XFER;
            default: begin
                if (accept) begin
                    state_d = ((req_kind == EXCHANGE) && !dec_reject) ? ST_EX1 : ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        kind_d       = accept ? req_kind : kind_q;
        src_d        = accept ? req_src  : src_q;
        dst_d        = accept ? req_dst  : dst_q;
        nib_d        = accept ? req_nib  : nib_q;
        op_low_d     = dec_op_low;
        op_high_d    = dec_op_high;
        bus_b_low_d  = dec_bus_b_low;
        bus_b_high_d = dec_bus_b_high;
        bus_b_out_d  = dec_bus_b_out;
        done_d       = dec_done;
        err_d        = dec_err;
    end

    // Handshake and step selection: a new request decodes as step 1 from the
    // request ports; later EXCHANGE steps decode from the latched fields
    always_comb begin
        req_ready  = (state_q == ST_IDLE) || (state_q == ST_XFER);
        accept     = req_valid && req_ready;
        dec_active = 1'b0;
        dec_kind   = req_kind;
        dec_src    = req_src;
        dec_dst    = req_dst;
        dec_nib    = req_nib;
        dec_step   = STEP_1;
        if (accept) begin
            dec_active = 1'b1;
        end else if ((state_q == ST_EX1) || (state_q == ST_EX2)) begin
            dec_active = 1'b1;
            dec_kind   = kind_q;
            dec_src    = src_q;
            dec_dst    = dst_q;
            dec_nib    = nib_q;
            dec_step   = (state_q == ST_EX1) ? STEP_2 : STEP_3;
        end
    end

    xfer_step_decode #(
        .HALF_WIDTH (HALF_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .TMP_REG    (TMP_REG),
        .IDX_W      (IDX_W)
    ) u_decode (
        .active     (dec_active),
        .kind       (dec_kind),
        .src        (dec_src),
        .dst        (dec_dst),
        .nib        (dec_nib),
        .step       (dec_step),
        .op_low     (dec_op_low),
        .op_high    (dec_op_high),
        .bus_b_low  (dec_bus_b_low),
        .bus_b_high (dec_bus_b_high),
        .bus_b_out  (dec_bus_b_out),
        .done       (dec_done),
        .err        (dec_err),
        .reject     (dec_reject)
    );

    assign op_low     = op_low_q;
    assign op_high    = op_high_q;
    assign bus_b_low  = bus_b_low_q;
    assign bus_b_high = bus_b_high_q;
    assign bus_b_out  = bus_b_out_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule
